timer_16bit_counter_core: RTL and testbench

Counting engine for Timer/Counter1. It consumes the Timer1 register-file outputs (TCCR1B, OCR1A, TIMSK, TIFR) and owns the live TCNT1 value. It prescales the system clock or synchronises the external T1 pin, advances TCNT1 in normal or CTC mode, and emits one-cycle flag-set pulses that the register file folds into TIFR. It also produces the gated interrupt requests for the interrupt controller.

---
 rtl/timer_16bit_counter_core.sv | 110 +++++++++++
 tb/tb_timer_16bit_counter_core.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_16bit_counter_core.sv
// Timer/Counter1 counting engine: prescaler, external T1 clock sync, TCNT1
// normal/CTC counting, compare/overflow flag-set pulses and gated interrupt requests.
module timer_16bit_counter_core #(
  parameter int unsigned OCF_BIT         = 4,
  parameter int unsigned TOV_BIT         = 2,
  parameter int unsigned PRESCALER_WIDTH = 10
) (
  input  logic        sysClock,
  input  logic        system_reset,
  input  logic [7:0]  TCCR1B_in,
  input  logic [15:0] OCR1A_in,
  input  logic [7:0]  TIMSK_in,
  input  logic [7:0]  TIFR_in,
  input  logic        tcnt_write_en,
  input  logic [15:0] tcnt_write_data,
  input  logic        psr_in,
  input  logic        t1_pin,
  output logic [15:0] TCNT1_out,
  output logic        ocf1a_set,
  output logic        tov1_set,
  output logic        irq_compa,
  output logic        irq_ovf
);

  logic [PRESCALER_WIDTH-1:0] prescaler;
  logic [15:0] tcnt;
  logic        t1_s1, t1_s2, t1_p;
  logic        cmp_block;
  logic        tick;
  logic        t1_rise, t1_fall;
  logic        ctc_mode;
  logic [2:0]  cs;
  logic        at_top;
  logic        at_max;

  assign cs       = TCCR1B_in[2:0];
  assign ctc_mode = TCCR1B_in[3];
  assign t1_rise  = t1_s2 & ~t1_p;
  assign t1_fall  = ~t1_s2 & t1_p;
  assign at_top   = (tcnt == OCR1A_in);
  assign at_max   = (tcnt == 16'hFFFF);

  always_ff @(posedge sysClock or negedge system_reset) begin
    if (!system_reset) begin
      prescaler <= '0;
    end else if (psr_in) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_ff @(posedge sysClock or negedge system_reset) begin
    if (!system_reset) begin
      t1_s1 <= 1'b0;
      t1_s2 <= 1'b0;
      t1_p  <= 1'b0;
    end else begin
      t1_s1 <= t1_pin;
      t1_s2 <= t1_s1;
      t1_p  <= t1_s2;
    end
  end

  always_comb begin
    tick = 1'b0;
    case (cs)
      3'b001:  tick = 1'b1;
      3'b010:  tick = &prescaler[2:0];
      3'b011:  tick = &prescaler[5:0];
      3'b100:  tick = &prescaler[7:0];
      3'b101:  tick = &prescaler[9:0];
      3'b110:  tick = t1_fall;
      3'b111:  tick = t1_rise;
      default: tick = 1'b0;
    endcase
  end

  // A CPU write wins over a coincident tick, and the written value is shielded
  // from matching until the following tick has moved past it.
  always_ff @(posedge sysClock or negedge system_reset) begin
    if (!system_reset) begin
      tcnt      <= '0;
      cmp_block <= 1'b0;
      ocf1a_set <= 1'b0;
      tov1_set  <= 1'b0;
    end else if (tcnt_write_en) begin
      tcnt      <= tcnt_write_data;
      cmp_block <= 1'b1;
      ocf1a_set <= 1'b0;
      tov1_set  <= 1'b0;
    end else if (tick) begin
      tcnt      <= (ctc_mode && at_top) ? 16'h0000 : tcnt + 16'd1;
      cmp_block <= 1'b0;
      ocf1a_set <= at_top & ~cmp_block;
      tov1_set  <= at_max;
    end else begin
      ocf1a_set <= 1'b0;
      tov1_set  <= 1'b0;
    end
  end

  assign TCNT1_out = tcnt;
  assign irq_compa = TIFR_in[OCF_BIT] & TIMSK_in[OCF_BIT];
  assign irq_ovf   = TIFR_in[TOV_BIT] & TIMSK_in[TOV_BIT];

  logic unused_bits;
  assign unused_bits = ^{TCCR1B_in[7:4], TIMSK_in, TIFR_in, prescaler};

endmodule

// File: tb/tb_timer_16bit_counter_core.sv
// Directed self-checking bench for timer_16bit_counter_core.
module tb_timer_16bit_counter_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  tccr1b = '0;
  logic [15:0] ocr1a = '0;
  logic [7:0]  timsk = '0;
  logic [7:0]  tifr = '0;
  logic        we = 1'b0;
  logic [15:0] wdata = '0;
  logic        psr = 1'b0;
  logic        t1 = 1'b0;
  logic [15:0] tcnt;
  logic        ocf, tov, irq_c, irq_o;

  int checks = 0;
  int failures = 0;

  timer_16bit_counter_core #(
    .OCF_BIT(4),
    .TOV_BIT(2),
    .PRESCALER_WIDTH(10)
  ) dut (
    .sysClock(clk),
    .system_reset(rst_n),
    .TCCR1B_in(tccr1b),
    .OCR1A_in(ocr1a),
    .TIMSK_in(timsk),
    .TIFR_in(tifr),
    .tcnt_write_en(we),
    .tcnt_write_data(wdata),
    .psr_in(psr),
    .t1_pin(t1),
    .TCNT1_out(tcnt),
    .ocf1a_set(ocf),
    .tov1_set(tov),
    .irq_compa(irq_c),
    .irq_ovf(irq_o)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset with the given TCCR1B/OCR1A; the first posedge after return is edge 1.
  task automatic do_reset(input logic [7:0] cr, input logic [15:0] ocr);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    tccr1b = cr;
    ocr1a = ocr;
    we = 1'b0;
    psr = 1'b0;
    t1 = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset(8'h01, 16'h1234);
    rst_n = 1'b0;
    #1;
    checks++;
    if (tcnt !== 16'h0000 || ocf !== 1'b0 || tov !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: tcnt=%h ocf=%b tov=%b expected 0000 0 0", tcnt, ocf, tov);
    end
    step(1);
    rst_n = 1'b1;
  endtask

  task automatic test_overflow;
    do_reset(8'h01, 16'h1234);
    we = 1'b1; wdata = 16'hFFFE;
    step(1);
    we = 1'b0;
    checks++;
    if (tcnt !== 16'hFFFE || tov !== 1'b0) begin
      failures++;
      $display("FAIL ovf_load: tcnt=%h tov=%b expected fffe 0", tcnt, tov);
    end
    step(1);
    checks++;
    if (tcnt !== 16'hFFFF || tov !== 1'b0) begin
      failures++;
      $display("FAIL ovf_ffff: tcnt=%h tov=%b expected ffff 0", tcnt, tov);
    end
    step(1);
    checks++;
    if (tcnt !== 16'h0000 || tov !== 1'b1 || ocf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_wrap: tcnt=%h tov=%b ocf=%b expected 0000 1 0", tcnt, tov, ocf);
    end
    step(1);
    checks++;
    if (tcnt !== 16'h0001 || tov !== 1'b0) begin
      failures++;
      $display("FAIL ovf_pulse_end: tcnt=%h tov=%b expected 0001 0", tcnt, tov);
    end
  endtask

  task automatic test_ctc;
    int bad = 0;
    logic [15:0] exp_cnt;
    logic exp_ocf;
    do_reset(8'h09, 16'h0004);
    for (int c = 1; c <= 100; c++) begin
      step(1);
      exp_cnt = 16'(c % 5);
      exp_ocf = (c % 5 == 0);
      if (tcnt !== exp_cnt || ocf !== exp_ocf || tov !== 1'b0) begin
        if (bad < 4)
          $display("FAIL ctc_cycle%0d: tcnt=%h ocf=%b tov=%b expected %h %b 0",
                   c, tcnt, ocf, tov, exp_cnt, exp_ocf);
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL ctc_sequence: bad_cycles=%0d expected 0", bad);
    end
  endtask

  task automatic test_prescale;
    do_reset(8'h02, 16'hFFFF);
    step(7);
    checks++;
    if (tcnt !== 16'h0000) begin
      failures++; $display("FAIL ps8_edge7: tcnt=%h expected 0000", tcnt);
    end
    step(1);
    checks++;
    if (tcnt !== 16'h0001) begin
      failures++; $display("FAIL ps8_edge8: tcnt=%h expected 0001", tcnt);
    end
    step(7);
    checks++;
    if (tcnt !== 16'h0001) begin
      failures++; $display("FAIL ps8_edge15: tcnt=%h expected 0001", tcnt);
    end
    step(1);
    checks++;
    if (tcnt !== 16'h0002) begin
      failures++; $display("FAIL ps8_edge16: tcnt=%h expected 0002", tcnt);
    end

    do_reset(8'h05, 16'hFFFF);
    step(1023);
    checks++;
    if (tcnt !== 16'h0000) begin
      failures++; $display("FAIL ps1024_edge1023: tcnt=%h expected 0000", tcnt);
    end
    step(1);
    checks++;
    if (tcnt !== 16'h0001) begin
      failures++; $display("FAIL ps1024_edge1024: tcnt=%h expected 0001", tcnt);
    end

    do_reset(8'h02, 16'hFFFF);
    step(5);
    psr = 1'b1;
    step(1);
    psr = 1'b0;
    step(7);
    checks++;
    if (tcnt !== 16'h0000) begin
      failures++; $display("FAIL psr_edge13: tcnt=%h expected 0000", tcnt);
    end
    step(1);
    checks++;
    if (tcnt !== 16'h0001) begin
      failures++; $display("FAIL psr_edge14: tcnt=%h expected 0001", tcnt);
    end
  endtask

  task automatic test_external;
    do_reset(8'h07, 16'hFFFF);
    for (int k = 0; k < 3; k++) begin
      t1 = 1'b1;
      step(2);
      checks++;
      if (tcnt !== 16'(k)) begin
        failures++; $display("FAIL ext_rise%0d_early: tcnt=%h expected %h", k, tcnt, 16'(k));
      end
      step(1);
      checks++;
      if (tcnt !== 16'(k + 1)) begin
        failures++; $display("FAIL ext_rise%0d_count: tcnt=%h expected %h", k, tcnt, 16'(k + 1));
      end
      step(2);
      t1 = 1'b0;
      step(5);
    end
    checks++;
    if (tcnt !== 16'h0003) begin
      failures++; $display("FAIL ext_rise_total: tcnt=%h expected 0003", tcnt);
    end

    do_reset(8'h06, 16'hFFFF);
    t1 = 1'b1;
    step(6);
    checks++;
    if (tcnt !== 16'h0000) begin
      failures++; $display("FAIL ext_fall_ignores_rise: tcnt=%h expected 0000", tcnt);
    end
    t1 = 1'b0;
    step(2);
    checks++;
    if (tcnt !== 16'h0000) begin
      failures++; $display("FAIL ext_fall_early: tcnt=%h expected 0000", tcnt);
    end
    step(1);
    checks++;
    if (tcnt !== 16'h0001) begin
      failures++; $display("FAIL ext_fall_count: tcnt=%h expected 0001", tcnt);
    end
  endtask

  task automatic test_write_priority;
    do_reset(8'h01, 16'h0010);
    we = 1'b1; wdata = 16'h0010;
    step(1);
    we = 1'b0;
    step(1);
    checks++;
    if (tcnt !== 16'h0011 || ocf !== 1'b0) begin
      failures++;
      $display("FAIL cmp_block: tcnt=%h ocf=%b expected 0011 0", tcnt, ocf);
    end
    we = 1'b1; wdata = 16'h000E;
    step(1);
    we = 1'b0;
    step(2);
    checks++;
    if (tcnt !== 16'h0010 || ocf !== 1'b0) begin
      failures++;
      $display("FAIL cmp_pre_match: tcnt=%h ocf=%b expected 0010 0", tcnt, ocf);
    end
    step(1);
    checks++;
    if (tcnt !== 16'h0011 || ocf !== 1'b1) begin
      failures++;
      $display("FAIL cmp_match: tcnt=%h ocf=%b expected 0011 1", tcnt, ocf);
    end
    we = 1'b1; wdata = 16'h0ABC;
    step(1);
    we = 1'b0;
    checks++;
    if (tcnt !== 16'h0ABC || ocf !== 1'b0) begin
      failures++;
      $display("FAIL write_vs_tick: tcnt=%h ocf=%b expected 0abc 0", tcnt, ocf);
    end
    tccr1b = 8'h00;
    step(4);
    checks++;
    if (tcnt !== 16'h0ABC) begin
      failures++; $display("FAIL stopped_hold: tcnt=%h expected 0abc", tcnt);
    end
    we = 1'b1; wdata = 16'h5555;
    step(1);
    we = 1'b0;
    step(1);
    checks++;
    if (tcnt !== 16'h5555) begin
      failures++; $display("FAIL stopped_write: tcnt=%h expected 5555", tcnt);
    end
  endtask

  task automatic test_ctc_top_max;
    do_reset(8'h09, 16'hFFFF);
    we = 1'b1; wdata = 16'hFFFE;
    step(1);
    we = 1'b0;
    step(1);
    checks++;
    if (tcnt !== 16'hFFFF || ocf !== 1'b0 || tov !== 1'b0) begin
      failures++;
      $display("FAIL ctc_max_pre: tcnt=%h ocf=%b tov=%b expected ffff 0 0", tcnt, ocf, tov);
    end
    step(1);
    checks++;
    if (tcnt !== 16'h0000 || ocf !== 1'b1 || tov !== 1'b1) begin
      failures++;
      $display("FAIL ctc_max_both: tcnt=%h ocf=%b tov=%b expected 0000 1 1", tcnt, ocf, tov);
    end
  endtask

  task automatic test_back_to_back;
    int bad = 0;
    do_reset(8'h09, 16'h0000);
    for (int c = 1; c <= 6; c++) begin
      step(1);
      if (tcnt !== 16'h0000 || ocf !== 1'b1) begin
        bad++;
        $display("FAIL b2b_cycle%0d: tcnt=%h ocf=%b expected 0000 1", c, tcnt, ocf);
      end
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL b2b_continuous: bad_cycles=%0d expected 0", bad);
    end
  endtask

  task automatic test_interrupts;
    tifr = 8'h10; timsk = 8'h00;
    #1;
    checks++;
    if (irq_c !== 1'b0 || irq_o !== 1'b0) begin
      failures++; $display("FAIL irq_masked: compa=%b ovf=%b expected 0 0", irq_c, irq_o);
    end
    timsk = 8'h10;
    #1;
    checks++;
    if (irq_c !== 1'b1 || irq_o !== 1'b0) begin
      failures++; $display("FAIL irq_compa_on: compa=%b ovf=%b expected 1 0", irq_c, irq_o);
    end
    tifr = 8'h04; timsk = 8'h04;
    #1;
    checks++;
    if (irq_c !== 1'b0 || irq_o !== 1'b1) begin
      failures++; $display("FAIL irq_ovf_on: compa=%b ovf=%b expected 0 1", irq_c, irq_o);
    end
    tifr = 8'hEB;
    #1;
    checks++;
    if (irq_o !== 1'b0) begin
      failures++; $display("FAIL irq_ovf_flag_clear: ovf=%b expected 0", irq_o);
    end
    tifr = 8'h00; timsk = 8'h00;
  endtask

  task automatic test_reset_mid;
    do_reset(8'h01, 16'h0123);
    we = 1'b1; wdata = 16'h0122;
    step(1);
    we = 1'b0;
    step(1);
    checks++;
    if (tcnt !== 16'h0123) begin
      failures++; $display("FAIL mid_pre: tcnt=%h expected 0123", tcnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tcnt !== 16'h0000 || ocf !== 1'b0 || tov !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: tcnt=%h ocf=%b tov=%b expected 0000 0 0", tcnt, ocf, tov);
    end
    step(1);
    rst_n = 1'b1;
    step(1);
    checks++;
    if (tcnt !== 16'h0001) begin
      failures++; $display("FAIL mid_resume: tcnt=%h expected 0001", tcnt);
    end
  endtask

  initial begin
    test_reset;
    test_overflow;
    test_ctc;
    test_prescale;
    test_external;
    test_write_priority;
    test_ctc_top_max;
    test_back_to_back;
    test_interrupts;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
